// File: rtl/md_seq.sv
// md_seq: multi-cycle mult/div sequencer with HI/LO registers (MD_DIV_ZERO_HOLD_EN keeps HI/LO on divide-by-zero)
module md_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        done
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] p_hi, p_lo;
  logic hold;
  logic is_mul, is_div, sgn, neg_a, neg_b, b_zero, issue, hold_n;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, hi_n, lo_n;
  logic [CW-1:0] lat;
  assign is_mul = op == 3'd1 || op == 3'd2;
  assign is_div = op == 3'd3 || op == 3'd4;
  assign sgn    = op == 3'd1 || op == 3'd3;
  assign issue  = start && !req && (is_mul || is_div);
  assign b_zero = B == 32'd0;
  assign prod   = {{32{sgn & A[31]}}, A} * {{32{sgn & B[31]}}, B};
  // Division works on magnitudes so the most-negative dividend needs no special case.
  assign neg_a  = sgn & A[31];
  assign neg_b  = sgn & B[31];
  assign a_mag  = neg_a ? ~A + 32'd1 : A;
  assign b_mag  = neg_b ? ~B + 32'd1 : B;
  assign q_mag  = b_zero ? 32'd0 : a_mag / b_mag;
  assign r_mag  = b_zero ? 32'd0 : a_mag % b_mag;
  assign q_s    = (neg_a ^ neg_b) ? ~q_mag + 32'd1 : q_mag;
  assign r_s    = neg_a ? ~r_mag + 32'd1 : r_mag;
  assign hi_n   = is_mul ? prod[63:32] : (b_zero ? A : r_s);
  assign lo_n   = is_mul ? prod[31:0] : (b_zero ? 32'hFFFF_FFFF : q_s);
  assign lat    = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
`ifdef MD_DIV_ZERO_HOLD_EN
  assign hold_n = is_div && b_zero;
`else
  assign hold_n = 1'b0;
`endif
  // Sequencer: issue into pending registers, count down, commit to HI/LO on the last RUN edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      hold  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (issue) begin
          p_hi  <= hi_n;
          p_lo  <= lo_n;
          hold  <= hold_n;
          cnt   <= lat;
          busy  <= 1'b1;
          state <= RUN;
        end else if (!req && !start && mthi) begin
          HI <= A;
        end else if (!req && !start && mtlo) begin
          LO <= A;
        end
      end else begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!hold) begin
            HI <= p_hi;
            LO <= p_lo;
          end
        end
      end
    end
  end
endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving busy cycles for div/divu.
REQ-003 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have req  input  1  exception/interrupt flush; suppresses new commands this cycle.
REQ-006 SHALL have start  input  1  issue strobe for a mult/div command.
REQ-007 SHALL have op  input  3  command: 1 mult, 2 multu, 3 div, 4 divu; all other codes are no-op.
REQ-008 SHALL have mthi  input  1  write A into HI.
REQ-009 SHALL have mtlo  input  1  write A into LO.
REQ-010 SHALL have A  input  32  operand rs.
REQ-011 SHALL have B  input  32  operand rt.
REQ-012 SHALL have busy  output  1  operation in flight; the pipeline stalls on it.
REQ-013 SHALL have HI  output  32  architectural HI register.
REQ-014 SHALL have LO  output  32  architectural LO register.
REQ-015 SHALL have done  output  1  one-cycle pulse when HI/LO first show a new result.

Function
REQ-016 SHALL implement FSM states IDLE and RUN plus a down-counter cnt sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-017 SHALL, in IDLE with start=1, req=0 and valid op, latch the result into pending registers pHI/pLO, load cnt with the latency, and enter RUN.
- mult/multu: pHI:pLO = 64-bit signed/unsigned product.
- div/divu: pLO = quotient, pHI = remainder, both truncated toward zero; remainder takes the sign of the dividend.
REQ-018 SHALL assert busy in every RUN cycle: start sampled at edge T gives busy=1 in cycles T+1 .. T+N, where N is the op latency.
REQ-019 SHALL, on the edge ending the last RUN cycle (cnt==1), copy pHI/pLO into HI/LO, return to IDLE, and assert done for exactly the next cycle.
REQ-020 SHALL keep HI/LO unchanged while in RUN, so in-flight results are invisible until completion.
REQ-021 SHALL ignore start, mthi and mtlo while busy=1.
REQ-022 SHALL ignore start, mthi and mtlo in any cycle with req=1, including the issue cycle itself.
REQ-023 SHALL let req arriving during RUN leave the in-flight operation running to completion, because it belongs to an older, committed instruction.
REQ-024 SHALL, in IDLE with req=0, make mthi write A into HI and mtlo write A into LO on the next edge; neither write asserts busy.
REQ-025 SHALL apply priority start > mthi > mtlo when several are asserted together in IDLE; only the highest-priority one takes effect.
REQ-026 SHALL treat start with an invalid op code as a no-op: stay in IDLE, busy=0.
REQ-027 SHALL treat divu 0x80000000 / 0xFFFFFFFF as unsigned; signed div 0x80000000 / -1 SHALL give LO=0x80000000, HI=0.

Reset
REQ-028 SHALL, on reset low, immediately force state=IDLE, cnt=0, busy=0, done=0, HI=0, LO=0, pHI=0, pLO=0, independent of clk.
REQ-029 SHALL abort any in-flight operation when reset asserts mid-RUN; no result is committed and done is not pulsed.
REQ-030 SHALL accept a command on the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL support macro MD_DIV_ZERO_HOLD_EN.
- Defined: div/divu with B==0 still runs DIV_CYCLES busy cycles, but HI/LO keep their prior values and done is still pulsed.
- Undefined: div/divu with B==0 commits LO=0xFFFFFFFF and HI=A.

Verification
REQ-032 SHALL verify: mult A=0xFFFFFFFE (-2), B=3 at edge T -> busy high cycles T+1..T+5; at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, done=1 for one cycle.
REQ-033 SHALL verify: divu A=17, B=5 -> busy for 10 cycles, then LO=3, HI=2; div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 SHALL verify: start+mult together with req=1 -> busy stays 0 and HI/LO unchanged; req=1 at cycle 3 of a running mult -> result still committed at the normal cycle.
REQ-035 SHALL verify: mthi A=0x12345678 while busy -> ignored; the same mthi in IDLE -> HI=0x12345678 next cycle with busy=0.
REQ-036 SHALL verify: reset pulled low at cycle 4 of a div -> busy=0, HI=LO=0 immediately with no clock edge, and no done pulse follows.
REQ-037 SHALL verify: div A=9, B=0 with HI=0xAA, LO=0xBB beforehand -> with MD_DIV_ZERO_HOLD_EN, HI=0xAA and LO=0xBB after 10 cycles; without it, LO=0xFFFFFFFF and HI=9.
